// File: rtl/add_sched_pkg.sv
// Shared types and constants for the round-robin adder scheduler.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package add_sched_pkg;

  // Operand width of the shared registered adder.
  localparam int W = 16;

  // Default requester-ID width (four requesters).
  localparam int IDW_DEFAULT = 2;

  // Scheduler control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RESP = 2'd2
  } state_t;

  // Number of requesters for a given ID width.
  function automatic int nreq_of(input int idw);
    return 1 << idw;
  endfunction

  // Unsigned carry-out recovered from the wrapped sum: wrap happened iff sum < a.
  function automatic logic carry_of(input logic [W-1:0] a, input logic [W-1:0] sum);
    return (sum < a);
  endfunction

  // Two's-complement overflow: operands agree in sign, result sign differs.
  function automatic logic ovf_of(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] sum);
    return (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
  endfunction

endpackage

// File: rtl/add_sched_if.sv
// Request and response channels between the issuing units and the scheduler.
// Latency: none (wires only).
// Backpressure: req channel granted by req_ready, rsp channel held by rsp_ready.
interface add_sched_if #(
  parameter int IDW = add_sched_pkg::IDW_DEFAULT,
  parameter int W   = add_sched_pkg::W
);
  import add_sched_pkg::*;

  localparam int NREQ = nreq_of(IDW);

  // Request side: one operand pair slot per requester, packed by index.
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;

  // Response side: tagged sum with flags.
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_carry;
  logic              rsp_ovf;

  // Requesters and the result consumer.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_ovf
  );

  // The scheduler.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_ovf
  );

endinterface

// File: rtl/add_sched_rr_pick.sv
// Round-robin picker: first valid request searching upward from last+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is presented as a grant.
module rr_pick #(
  parameter int IDW = add_sched_pkg::IDW_DEFAULT
) (
  input  logic [(1<<IDW)-1:0] req,
  input  logic [IDW-1:0]      last,
  output logic [(1<<IDW)-1:0] gnt,
  output logic [IDW-1:0]      gnt_id,
  output logic                gnt_any
);
  import add_sched_pkg::*;

  localparam int NREQ = nreq_of(IDW);

  logic [IDW-1:0] idx;

  // Walk NREQ slots starting just after the last grant; the wrap falls out of IDW-bit addition.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = last + IDW'(i);
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
    gnt = gnt_any ? (NREQ'(1) << gnt_id) : '0;
  end

endmodule

// File: rtl/add_sched.sv
// Round-robin scheduler sharing one registered adder among NREQ requesters.
// Latency: result valid two cycles after the accepting edge; one result per two cycles at best.
// Backpressure: rsp_ready low holds the result and blocks new grants; requests wait in place.
module add_sched #(
  parameter int IDW = add_sched_pkg::IDW_DEFAULT,
  parameter int W   = add_sched_pkg::W
) (
  input  logic         CLK,
  input  logic         RST,
  add_sched_if.slave   bus,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W-1:0] add_r,
  output logic         busy
);
  import add_sched_pkg::*;

  localparam int NREQ = nreq_of(IDW);

  state_t          state_q;
  state_t          state_d;
  logic [IDW-1:0]  last_q;
  logic [IDW-1:0]  id_q;
  logic [W-1:0]    op_a_q;
  logic [W-1:0]    op_b_q;

  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_id;
  logic            pick_any;
  logic            pick_en;
  logic            xfer;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;

  rr_pick #(.IDW(IDW)) u_pick (
    .req     (bus.req_valid),
    .last    (last_q),
    .gnt     (pick_gnt),
    .gnt_id  (pick_id),
    .gnt_any (pick_any)
  );

  // Grant window: idle, or a response being consumed this cycle; never while reset is asserted.
  always_comb begin
    pick_en = 1'b0;
    case (state_q)
      IDLE:    pick_en = 1'b1;
      RESP:    pick_en = bus.rsp_ready;
      default: pick_en = 1'b0;
    endcase
    if (RST) begin
      pick_en = 1'b0;
    end
    bus.req_ready = pick_en ? pick_gnt : '0;
    xfer          = pick_en && pick_any;
  end

  // Steer the granted requester's operand pair toward the holding registers.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_id == IDW'(i)) begin
        sel_a = bus.req_a[i*W +: W];
        sel_b = bus.req_b[i*W +: W];
      end
    end
  end

  // Next-state logic; a consumed response can chain straight into the next load.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = xfer ? LOAD : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, priority pointer and operand holding registers; operands change only on a transfer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      last_q  <= IDW'(NREQ - 1);
      id_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        op_a_q <= sel_a;
        op_b_q <= sel_b;
        id_q   <= pick_id;
        last_q <= pick_id;
      end
    end
  end

  // The adder always sees the held operands, so a stalled response keeps recomputing the same sum.
  always_comb begin
    add_a         = op_a_q;
    add_b         = op_b_q;
    busy          = (state_q != IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_id    = id_q;
    bus.rsp_sum   = add_r;
    bus.rsp_carry = carry_of(op_a_q, add_r);
    bus.rsp_ovf   = ovf_of(op_a_q, op_b_q, add_r);
  end

  // At most one requester is granted in any cycle.
  a_grant_onehot: assert property (@(posedge CLK) disable iff (RST) $onehot0(bus.req_ready));

  // LOAD lasts exactly one cycle.
  a_load_one_cycle: assert property (@(posedge CLK) disable iff (RST)
    (state_q == LOAD) |=> (state_q == RESP));

  // A stalled response keeps its tag and operands.
  a_rsp_hold: assert property (@(posedge CLK) disable iff (RST)
    (bus.rsp_valid && !bus.rsp_ready) |=> (bus.rsp_valid && $stable(bus.rsp_id)
                                           && $stable(op_a_q) && $stable(op_b_q)));

endmodule

// File: tb/tb_add_sched.sv
module tb_add_sched;

  logic        CLK;
  logic        RST;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_r;
  logic        busy;

  add_sched_if #(.IDW(2), .W(16)) bus ();

  add_sched #(.IDW(2), .W(16)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .bus   (bus),
    .add_a (add_a),
    .add_b (add_b),
    .add_r (add_r),
    .busy  (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Shared registered adder beside the scheduler.
  always @(posedge CLK) add_r <= add_a + add_b;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] sum;
    logic        c;
    logic        o;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic exp_t make_exp(input logic [1:0] id, input logic [15:0] a,
                                    input logic [15:0] b);
    exp_t r;
    logic [16:0] s;
    s     = {1'b0, a} + {1'b0, b};
    r.id  = id;
    r.sum = s[15:0];
    r.c   = s[16];
    r.o   = (a[15] == b[15]) && (s[15] != a[15]);
    return r;
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.req_a[i*16 +: 16] = a;
    bus.req_b[i*16 +: 16] = b;
  endtask

  task automatic apply_reset();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    @(negedge CLK);
    n_total++;
    if (bus.req_ready !== 4'b0000) $display("FAIL reset_no_grant: req_ready=%b want 0000", bus.req_ready);
    else n_pass++;
    cyc();
    RST = 1'b0;
    bus.req_valid = '0;
    @(negedge CLK);
    n_total++;
    if ({bus.rsp_valid, busy, bus.req_ready} !== 6'b0)
      $display("FAIL reset_ctrl: rsp_valid=%b busy=%b req_ready=%b want 0 0 0000",
               bus.rsp_valid, busy, bus.req_ready);
    else n_pass++;
    n_total++;
    if ({add_a, add_b, bus.rsp_id} !== 34'h0)
      $display("FAIL reset_regs: add_a=%h add_b=%h rsp_id=%0d want 0 0 0", add_a, add_b, bus.rsp_id);
    else n_pass++;
    cyc();
  endtask

  task automatic test_single();
    apply_reset();
    set_op(2, 16'h0003, 16'h0004);
    bus.req_valid = 4'b0100;
    @(negedge CLK);
    n_total++;
    if (bus.req_ready !== 4'b0100) $display("FAIL single_grant: req_ready=%b want 0100", bus.req_ready);
    else n_pass++;
    sb.push_back(make_exp(2'd2, 16'h0003, 16'h0004));
    cyc();
    bus.req_valid = '0;
    @(negedge CLK);
    n_total++;
    if ({bus.rsp_valid, busy} !== 2'b01)
      $display("FAIL single_load: rsp_valid=%b busy=%b want 0 1", bus.rsp_valid, busy);
    else n_pass++;
    cyc();
    @(negedge CLK);
    n_total++;
    if (bus.rsp_valid !== 1'b1 || sb.size() == 0) begin
      $display("FAIL single_rsp_valid: rsp_valid=%b want 1 two cycles after transfer", bus.rsp_valid);
    end else begin
      e = sb.pop_front();
      if ({bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf} !== {e.id, e.sum, e.c, e.o})
        $display("FAIL single_rsp: id=%0d sum=%h c=%b o=%b want id=%0d sum=%h c=%b o=%b",
                 bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf, e.id, e.sum, e.c, e.o);
      else n_pass++;
    end
    cyc();
    @(negedge CLK);
    n_total++;
    if ({bus.rsp_valid, busy} !== 2'b00)
      $display("FAIL single_idle: rsp_valid=%b busy=%b want 0 0", bus.rsp_valid, busy);
    else n_pass++;
    cyc();
  endtask

  task automatic test_round_robin();
    logic [1:0] nxt;
    logic [1:0] last_m;
    int ng = 0;
    int last_c = 0;
    apply_reset();
    last_m = 2'd3;
    for (int i = 0; i < 4; i++) set_op(i, 16'(16'h1000 * (i + 1) + i), 16'(16'h0010 * (i + 1)));
    bus.req_valid = 4'hF;
    for (int c = 0; c < 40 && (ng < 5 || sb.size() > 0); c++) begin
      @(negedge CLK);
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL rr_rsp: unexpected result id=%0d sum=%h", bus.rsp_id, bus.rsp_sum);
        end else begin
          e = sb.pop_front();
          if ({bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf} !== {e.id, e.sum, e.c, e.o})
            $display("FAIL rr_rsp: id=%0d sum=%h c=%b o=%b want id=%0d sum=%h c=%b o=%b",
                     bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf, e.id, e.sum, e.c, e.o);
          else n_pass++;
        end
      end
      if ((bus.req_ready & bus.req_valid) != 4'b0) begin
        nxt = last_m + 2'd1;
        n_total++;
        if (bus.req_ready !== (4'b0001 << nxt))
          $display("FAIL rr_order: grant %0d req_ready=%b want %b", ng, bus.req_ready, 4'b0001 << nxt);
        else n_pass++;
        if (ng > 0) begin
          n_total++;
          if (c - last_c != 2) $display("FAIL rr_gap: grant spacing %0d cycles want 2", c - last_c);
          else n_pass++;
        end
        sb.push_back(make_exp(nxt, bus.req_a[nxt*16 +: 16], bus.req_b[nxt*16 +: 16]));
        last_m = nxt;
        last_c = c;
        ng++;
      end
      cyc();
      if (ng >= 5) bus.req_valid = '0;
    end
    n_total++;
    if (ng != 5 || sb.size() != 0)
      $display("FAIL rr_done: grants=%0d pending=%0d want 5 0", ng, sb.size());
    else n_pass++;
  endtask

  task automatic test_flags();
    logic [15:0] ta[3];
    logic [15:0] tb[3];
    exp_t        te[3];
    logic        got;
    ta[0] = 16'hFFFF; tb[0] = 16'h0001; te[0] = '{2'd0, 16'h0000, 1'b1, 1'b0};
    ta[1] = 16'h7FFF; tb[1] = 16'h0001; te[1] = '{2'd0, 16'h8000, 1'b0, 1'b1};
    ta[2] = 16'h8000; tb[2] = 16'h8000; te[2] = '{2'd0, 16'h0000, 1'b1, 1'b1};
    apply_reset();
    for (int v = 0; v < 3; v++) begin
      set_op(0, ta[v], tb[v]);
      bus.req_valid = 4'b0001;
      got = 1'b0;
      for (int k = 0; k < 4 && !got; k++) begin
        @(negedge CLK);
        if (bus.req_ready[0]) begin
          got = 1'b1;
          sb.push_back(te[v]);
        end
        cyc();
      end
      bus.req_valid = '0;
      n_total++;
      if (!got) $display("FAIL flags_grant: vector %0d never granted", v);
      else n_pass++;
      got = 1'b0;
      for (int k = 0; k < 6 && !got; k++) begin
        @(negedge CLK);
        if (bus.rsp_valid && sb.size() > 0) begin
          got = 1'b1;
          e = sb.pop_front();
          n_total++;
          if ({bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf} !== {e.id, e.sum, e.c, e.o})
            $display("FAIL flags_%0d: id=%0d sum=%h c=%b o=%b want id=%0d sum=%h c=%b o=%b", v,
                     bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf, e.id, e.sum, e.c, e.o);
          else n_pass++;
        end
        cyc();
      end
      n_total++;
      if (!got) $display("FAIL flags_timeout: vector %0d no response", v);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic got;
    apply_reset();
    bus.rsp_ready = 1'b0;
    set_op(1, 16'h1111, 16'h0101);
    bus.req_valid = 4'b0010;
    @(negedge CLK);
    n_total++;
    if (bus.req_ready !== 4'b0010) $display("FAIL bp_grant1: req_ready=%b want 0010", bus.req_ready);
    else n_pass++;
    sb.push_back(make_exp(2'd1, 16'h1111, 16'h0101));
    cyc();
    set_op(1, 16'h0002, 16'h0003);
    @(negedge CLK);
    n_total++;
    if (bus.req_ready !== 4'b0000) $display("FAIL bp_load_rdy: req_ready=%b want 0000", bus.req_ready);
    else n_pass++;
    cyc();
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      n_total++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum} !== {1'b1, 2'd1, 16'h1212})
        $display("FAIL bp_hold: cycle %0d valid=%b id=%0d sum=%h want 1 1 1212",
                 k, bus.rsp_valid, bus.rsp_id, bus.rsp_sum);
      else n_pass++;
      n_total++;
      if (bus.req_ready !== 4'b0000) $display("FAIL bp_rdy: cycle %0d req_ready=%b want 0000", k, bus.req_ready);
      else n_pass++;
      cyc();
    end
    bus.rsp_ready = 1'b1;
    @(negedge CLK);
    n_total++;
    if (!bus.rsp_valid || sb.size() == 0) begin
      $display("FAIL bp_rsp1: rsp_valid=%b want 1 at release", bus.rsp_valid);
    end else begin
      e = sb.pop_front();
      if ({bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf} !== {e.id, e.sum, e.c, e.o})
        $display("FAIL bp_rsp1: id=%0d sum=%h want id=%0d sum=%h", bus.rsp_id, bus.rsp_sum, e.id, e.sum);
      else n_pass++;
    end
    n_total++;
    if (bus.req_ready !== 4'b0010) $display("FAIL bp_release_grant: req_ready=%b want 0010", bus.req_ready);
    else n_pass++;
    sb.push_back(make_exp(2'd1, 16'h0002, 16'h0003));
    cyc();
    bus.req_valid = '0;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge CLK);
      if (bus.rsp_valid && sb.size() > 0) begin
        got = 1'b1;
        e = sb.pop_front();
        n_total++;
        if ({bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf} !== {e.id, e.sum, e.c, e.o})
          $display("FAIL bp_rsp2: id=%0d sum=%h want id=%0d sum=%h", bus.rsp_id, bus.rsp_sum, e.id, e.sum);
        else n_pass++;
      end
      cyc();
    end
    n_total++;
    if (!got) $display("FAIL bp_rsp2_timeout: no second response");
    else n_pass++;
  endtask

  task automatic test_rst_in_resp();
    logic got;
    apply_reset();
    bus.rsp_ready = 1'b0;
    set_op(2, 16'h1000, 16'h0234);
    set_op(0, 16'h0A0A, 16'h0505);
    bus.req_valid = 4'b0100;
    @(negedge CLK);
    sb.push_back(make_exp(2'd2, 16'h1000, 16'h0234));
    cyc();
    bus.req_valid = '0;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge CLK);
      if (bus.rsp_valid) got = 1'b1;
      else cyc();
    end
    n_total++;
    if (!got || bus.rsp_sum !== 16'h1234)
      $display("FAIL rst_pre_sum: valid=%b sum=%h want 1 1234", got, bus.rsp_sum);
    else n_pass++;
    RST = 1'b1;
    bus.req_valid = 4'b1001;
    bus.rsp_ready = 1'b1;
    sb.delete();
    #1;
    n_total++;
    if (bus.req_ready !== 4'b0000) $display("FAIL rst_no_grant: req_ready=%b want 0000", bus.req_ready);
    else n_pass++;
    cyc();
    RST = 1'b0;
    @(negedge CLK);
    n_total++;
    if ({bus.rsp_valid, add_a, add_b} !== 33'h0)
      $display("FAIL rst_clear: rsp_valid=%b add_a=%h add_b=%h want 0 0 0", bus.rsp_valid, add_a, add_b);
    else n_pass++;
    n_total++;
    if (bus.req_ready !== 4'b0001) $display("FAIL rst_prio: req_ready=%b want 0001", bus.req_ready);
    else n_pass++;
    sb.push_back(make_exp(2'd0, 16'h0A0A, 16'h0505));
    cyc();
    bus.req_valid = '0;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge CLK);
      if (bus.rsp_valid && sb.size() > 0) begin
        got = 1'b1;
        e = sb.pop_front();
        n_total++;
        if ({bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf} !== {e.id, e.sum, e.c, e.o})
          $display("FAIL rst_next_rsp: id=%0d sum=%h want id=%0d sum=%h", bus.rsp_id, bus.rsp_sum, e.id, e.sum);
        else n_pass++;
      end
      cyc();
    end
    n_total++;
    if (!got) $display("FAIL rst_next_timeout: no response after reset");
    else n_pass++;
  endtask

  task automatic test_pulse();
    int n_rsp = 0;
    int n3 = 0;
    int bad_grant = 0;
    apply_reset();
    set_op(0, 16'h0005, 16'h0006);
    set_op(3, 16'h0007, 16'h0008);
    bus.req_valid = 4'b1001;
    @(negedge CLK);
    n_total++;
    if (bus.req_ready !== 4'b0001) $display("FAIL pulse_grant0: req_ready=%b want 0001", bus.req_ready);
    else n_pass++;
    sb.push_back(make_exp(2'd0, 16'h0005, 16'h0006));
    cyc();
    bus.req_valid = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (bus.req_ready != 4'b0) bad_grant++;
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_rsp++;
        if (bus.rsp_id == 2'd3) n3++;
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL pulse_rsp: unexpected result id=%0d sum=%h", bus.rsp_id, bus.rsp_sum);
        end else begin
          e = sb.pop_front();
          if ({bus.rsp_id, bus.rsp_sum} !== {e.id, e.sum})
            $display("FAIL pulse_rsp: id=%0d sum=%h want id=%0d sum=%h", bus.rsp_id, bus.rsp_sum, e.id, e.sum);
          else n_pass++;
        end
      end
      cyc();
    end
    n_total++;
    if (n3 != 0) $display("FAIL pulse_no_id3: %0d results for id 3 want 0", n3);
    else n_pass++;
    n_total++;
    if (n_rsp != 1) $display("FAIL pulse_rsp_count: %0d results want 1", n_rsp);
    else n_pass++;
    n_total++;
    if (bad_grant != 0) $display("FAIL pulse_no_grant: %0d stray grants want 0", bad_grant);
    else n_pass++;
  endtask

  initial begin
    RST = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_flags();
    test_backpressure();
    test_rst_in_resp();
    test_pulse();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
